// File: rtl/cache_axi_pkg.sv
// Shared constants and types for the cache read arbiter: AXI read IDs,
// burst lengths and the AR grant-state encoding.
package cache_axi_pkg;

  localparam logic [3:0] ARID_INST  = 4'd0;
  localparam logic [3:0] ARID_DATA  = 4'd1;

  localparam logic [7:0] ARLEN_LINE = 8'd3;
  localparam logic [7:0] ARLEN_WORD = 8'd0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GNT_I = 2'd1,
    ST_GNT_D = 2'd2
  } gnt_state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way combinational selector. A lone request always wins; on a tie the
// requester named by ptr wins (ptr=1 favours req[1]). Output is one-hot or 0.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       ptr,
  output logic [1:0] gnt
);

  // Pick the single requester, or break a tie with ptr.
  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      gnt = ptr ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/cache_rd_arbiter.sv
// Arbitrates icache and dcache read requests onto one AXI AR channel and
// routes R beats back by ID. One read per ID may be outstanding. A dcache
// read that hits the line of a pending buffered write is held off.
// Build option: define CACHE_ARB_RR_EN for round-robin tie-breaking;
// otherwise dcache wins every tie.
module cache_rd_arbiter
  import cache_axi_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic              i_rd_req,
  input  logic [ADDR_W-1:0] i_rd_addr,
  input  logic              i_rd_burst,
  output logic              i_rd_rdy,
  output logic              i_ret_valid,
  input  logic              d_rd_req,
  input  logic [ADDR_W-1:0] d_rd_addr,
  input  logic              d_rd_burst,
  output logic              d_rd_rdy,
  output logic              d_ret_valid,
  input  logic              wr_busy,
  input  logic [ADDR_W-1:0] wr_addr,
  output logic [3:0]        arid,
  output logic [ADDR_W-1:0] araddr,
  output logic [7:0]        arlen,
  output logic              arvalid,
  input  logic              arready,
  input  logic [3:0]        rid,
  input  logic              rlast,
  input  logic              rvalid,
  output logic              rready
);

  gnt_state_e        state_q, state_d;
  logic [ADDR_W-1:0] araddr_q, araddr_d;
  logic [7:0]        arlen_q, arlen_d;
  logic [3:0]        arid_q, arid_d;
  logic              i_out_q, i_out_d;
  logic              d_out_q, d_out_d;
  logic              ptr;
  logic              wr_hazard;
  logic              i_elig, d_elig;
  logic [1:0]        gnt;

`ifdef CACHE_ARB_RR_EN
  logic              ptr_q, ptr_d;
  assign ptr = ptr_q;
`else
  assign ptr = 1'b1;
`endif

  // Same 16-byte line as the pending write: the read would see stale data.
  assign wr_hazard = wr_busy && ((wr_addr >> 4) == (d_rd_addr >> 4));
  assign i_elig    = i_rd_req && !i_out_q;
  assign d_elig    = d_rd_req && !d_out_q && !wr_hazard;

  rr_arb2 u_arb (
    .req ({d_elig, i_elig}),
    .ptr (ptr),
    .gnt (gnt)
  );

  // R channel steering and AR handshake strobes.
  always_comb begin
    rready      = ((rid == ARID_INST) && i_out_q) || ((rid == ARID_DATA) && d_out_q);
    i_ret_valid = rvalid && rready && (rid == ARID_INST);
    d_ret_valid = rvalid && rready && (rid == ARID_DATA);
    arvalid     = (state_q != ST_IDLE);
    i_rd_rdy    = (state_q == ST_GNT_I) && arready;
    d_rd_rdy    = (state_q == ST_GNT_D) && arready;
    arid        = arid_q;
    araddr      = araddr_q;
    arlen       = arlen_q;
  end

  // Grant FSM next state, AR payload capture and outstanding flags.
  always_comb begin
    state_d  = state_q;
    araddr_d = araddr_q;
    arlen_d  = arlen_q;
    arid_d   = arid_q;
    i_out_d  = i_out_q;
    d_out_d  = d_out_q;
`ifdef CACHE_ARB_RR_EN
    ptr_d    = ptr_q;
`endif
    if (i_ret_valid && rlast) i_out_d = 1'b0;
    if (d_ret_valid && rlast) d_out_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (gnt[0]) begin
          state_d  = ST_GNT_I;
          araddr_d = i_rd_addr;
          arlen_d  = i_rd_burst ? ARLEN_LINE : ARLEN_WORD;
          arid_d   = ARID_INST;
        end else if (gnt[1]) begin
          state_d  = ST_GNT_D;
          araddr_d = d_rd_addr;
          arlen_d  = d_rd_burst ? ARLEN_LINE : ARLEN_WORD;
          arid_d   = ARID_DATA;
        end
      end
      ST_GNT_I: begin
        if (arready) begin
          state_d = ST_IDLE;
          i_out_d = 1'b1;
`ifdef CACHE_ARB_RR_EN
          ptr_d   = 1'b1;
`endif
        end
      end
      ST_GNT_D: begin
        if (arready) begin
          state_d = ST_IDLE;
          d_out_d = 1'b1;
`ifdef CACHE_ARB_RR_EN
          ptr_d   = 1'b0;
`endif
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q  <= ST_IDLE;
      araddr_q <= '0;
      arlen_q  <= '0;
      arid_q   <= '0;
      i_out_q  <= 1'b0;
      d_out_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      araddr_q <= araddr_d;
      arlen_q  <= arlen_d;
      arid_q   <= arid_d;
      i_out_q  <= i_out_d;
      d_out_q  <= d_out_d;
    end
  end

`ifdef CACHE_ARB_RR_EN
  // Round-robin pointer; resets pointing at dcache.
  always_ff @(posedge aclk) begin
    if (!aresetn) ptr_q <= 1'b1;
    else          ptr_q <= ptr_d;
  end
`endif

endmodule

// File: tb/tb_cache_rd_arbiter.sv
// Bench for cache_rd_arbiter: transaction-level model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_cache_rd_arbiter;

  localparam int ADDR_W = 32;

  logic              aclk = 1'b0;
  logic              aresetn;
  logic              i_rd_req, i_rd_burst, d_rd_req, d_rd_burst;
  logic [ADDR_W-1:0] i_rd_addr, d_rd_addr, wr_addr;
  logic              wr_busy, arready, rlast, rvalid;
  logic [3:0]        rid;
  logic              i_rd_rdy, i_ret_valid, d_rd_rdy, d_ret_valid;
  logic [3:0]        arid;
  logic [ADDR_W-1:0] araddr;
  logic [7:0]        arlen;
  logic              arvalid, rready;

  cache_rd_arbiter #(.ADDR_W(ADDR_W)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .i_rd_req(i_rd_req), .i_rd_addr(i_rd_addr), .i_rd_burst(i_rd_burst),
    .i_rd_rdy(i_rd_rdy), .i_ret_valid(i_ret_valid),
    .d_rd_req(d_rd_req), .d_rd_addr(d_rd_addr), .d_rd_burst(d_rd_burst),
    .d_rd_rdy(d_rd_rdy), .d_ret_valid(d_ret_valid),
    .wr_busy(wr_busy), .wr_addr(wr_addr),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arvalid(arvalid),
    .arready(arready), .rid(rid), .rlast(rlast), .rvalid(rvalid),
    .rready(rready)
  );

  always #5 aclk = ~aclk;

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Model: who owns the AR channel (-1 none, 0 icache, 1 dcache), which IDs
  // have a read in flight, the tie-break favourite, and the last AR payload.
  int          m_owner = -1;
  logic        m_out[2] = '{1'b0, 1'b0};
  int          m_fav = 1;
  logic [31:0] m_addr = '0;
  logic [7:0]  m_len = '0;
  logic [3:0]  m_id = '0;

  // Values seen in the cycle before the most recent rising edge.
  logic        s_ar_hs, s_arvalid, s_irdy, s_drdy, s_iret, s_dret, s_rready;
  logic [3:0]  s_arid;
  logic [31:0] s_araddr;
  logic [7:0]  s_arlen;

  always @(negedge aclk) begin
    logic e_rready, e_iret, e_dret;
    int   n_owner, pick, n_fav;
    logic n_out[2];
    logic [31:0] n_addr;
    logic [7:0]  n_len;
    logic [3:0]  n_id;
    logic el_i, el_d;

    e_rready = (rid == 4'd0 && m_out[0]) || (rid == 4'd1 && m_out[1]);
    e_iret   = rvalid && e_rready && rid == 4'd0;
    e_dret   = rvalid && e_rready && rid == 4'd1;
    check("arvalid",     {31'd0, arvalid},     {31'd0, m_owner >= 0});
    check("i_rd_rdy",    {31'd0, i_rd_rdy},    {31'd0, m_owner == 0 && arready});
    check("d_rd_rdy",    {31'd0, d_rd_rdy},    {31'd0, m_owner == 1 && arready});
    check("rready",      {31'd0, rready},      {31'd0, e_rready});
    check("i_ret_valid", {31'd0, i_ret_valid}, {31'd0, e_iret});
    check("d_ret_valid", {31'd0, d_ret_valid}, {31'd0, e_dret});
    check("araddr",      araddr,               m_addr);
    check("arlen",       {24'd0, arlen},       {24'd0, m_len});
    check("arid",        {28'd0, arid},        {28'd0, m_id});

    s_ar_hs   <= arvalid && arready;
    s_arvalid <= arvalid;
    s_irdy    <= i_rd_rdy;
    s_drdy    <= d_rd_rdy;
    s_iret    <= i_ret_valid;
    s_dret    <= d_ret_valid;
    s_rready  <= rready;
    s_arid    <= arid;
    s_araddr  <= araddr;
    s_arlen   <= arlen;

    n_owner = m_owner; n_out = m_out; n_fav = m_fav;
    n_addr = m_addr; n_len = m_len; n_id = m_id;
    if (!aresetn) begin
      n_owner = -1; n_out = '{1'b0, 1'b0}; n_fav = 1;
      n_addr = '0; n_len = '0; n_id = '0;
    end else begin
      if (e_iret && rlast) n_out[0] = 1'b0;
      if (e_dret && rlast) n_out[1] = 1'b0;
      if (m_owner < 0) begin
        el_i = i_rd_req && !m_out[0];
        el_d = d_rd_req && !m_out[1] &&
               !(wr_busy && wr_addr[31:4] == d_rd_addr[31:4]);
        pick = -1;
        if (el_i && el_d) pick = m_fav;
        else if (el_i)    pick = 0;
        else if (el_d)    pick = 1;
        if (pick >= 0) begin
          n_owner = pick;
          n_id    = pick[3:0];
          n_addr  = (pick == 0) ? i_rd_addr : d_rd_addr;
          n_len   = (((pick == 0) ? i_rd_burst : d_rd_burst)) ? 8'd3 : 8'd0;
        end
      end else if (arready) begin
        n_out[m_owner] = 1'b1;
`ifdef CACHE_ARB_RR_EN
        n_fav = 1 - m_owner;
`endif
        n_owner = -1;
      end
    end
    m_owner <= n_owner; m_out <= n_out; m_fav <= n_fav;
    m_addr <= n_addr; m_len <= n_len; m_id <= n_id;
  end

  // One clock; requesters drop their request after seeing their rdy.
  task automatic tick();
    @(posedge aclk);
    #1;
    if (s_irdy) i_rd_req = 1'b0;
    if (s_drdy) d_rd_req = 1'b0;
  endtask

  task automatic wait_hs(input string name, input logic [3:0] id,
                         input logic [31:0] addr, input logic [7:0] len);
    bit seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      if (s_ar_hs) begin
        seen = 1;
        check({name, "_arid"},   {28'd0, s_arid},  {28'd0, id});
        check({name, "_araddr"}, s_araddr,         addr);
        check({name, "_arlen"},  {24'd0, s_arlen}, {24'd0, len});
      end
    end
    if (!seen) check({name, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic beat(input logic [3:0] id, input logic last);
    rvalid = 1'b1; rid = id; rlast = last;
    tick();
    rvalid = 1'b0; rlast = 1'b0;
  endtask

  initial begin
    int cnt;
    bit seen;
    aresetn = 1'b0;
    i_rd_req = 0; i_rd_addr = '0; i_rd_burst = 0;
    d_rd_req = 0; d_rd_addr = '0; d_rd_burst = 0;
    wr_busy = 0; wr_addr = '0; arready = 0;
    rid = 4'd0; rlast = 0; rvalid = 1'b1;
    repeat (3) tick();
    check("rst_arvalid", {31'd0, arvalid}, 32'd0);
    check("rst_rready",  {31'd0, rready},  32'd0);
    check("rst_iret",    {31'd0, i_ret_valid}, 32'd0);
    check("rst_araddr",  araddr, 32'd0);

    // Simultaneous requests after reset: dcache first, then icache.
    rvalid = 0; aresetn = 1'b1; arready = 1'b1;
    i_rd_req = 1; i_rd_addr = 32'h100; i_rd_burst = 0;
    d_rd_req = 1; d_rd_addr = 32'h200; d_rd_burst = 0;
    wait_hs("first_d", 4'd1, 32'h200, 8'd0);
    wait_hs("next_i",  4'd0, 32'h100, 8'd0);
    beat(4'd1, 1'b1);
    check("d_single_ret", {31'd0, s_dret}, 32'd1);
    beat(4'd0, 1'b1);
    check("i_single_ret", {31'd0, s_iret}, 32'd1);

    // Write-line hazard blocks dcache but not icache.
    wr_busy = 1; wr_addr = 32'h1C00_0010;
    d_rd_req = 1; d_rd_addr = 32'h1C00_001C; d_rd_burst = 0;
    i_rd_req = 1; i_rd_addr = 32'h1C00_0100; i_rd_burst = 1;
    wait_hs("i_hazard", 4'd0, 32'h1C00_0100, 8'd3);
    repeat (4) begin
      tick();
      check("no_d_gnt_hazard", {31'd0, s_arvalid}, 32'd0);
    end
    wr_busy = 0;
    wait_hs("d_after_wr", 4'd1, 32'h1C00_001C, 8'd0);

    // Four-beat icache fill, then icache can be granted again.
    cnt = 0;
    for (int b = 0; b < 4; b++) begin
      beat(4'd0, b == 3);
      cnt += int'(s_iret);
    end
    check("i_fill_beats", cnt, 32'd4);
    i_rd_req = 1; i_rd_addr = 32'h2000; i_rd_burst = 0;
    wait_hs("i_regrant", 4'd0, 32'h2000, 8'd0);
    beat(4'd1, 1'b1);
    beat(4'd0, 1'b1);

    // AR stall: payload stable, no rdy until arready.
    arready = 0;
    d_rd_req = 1; d_rd_addr = 32'h3000; d_rd_burst = 1;
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      tick();
      seen = s_arvalid;
    end
    check("stall_arvalid_seen", {31'd0, seen}, 32'd1);
    repeat (5) begin
      tick();
      check("stall_arvalid", {31'd0, s_arvalid}, 32'd1);
      check("stall_araddr",  s_araddr, 32'h3000);
      check("stall_arlen",   {24'd0, s_arlen}, 32'd3);
      check("stall_drdy",    {31'd0, s_drdy}, 32'd0);
    end
    arready = 1;
    wait_hs("d_after_stall", 4'd1, 32'h3000, 8'd3);

    // Beat for an ID with nothing outstanding is refused.
    beat(4'd0, 1'b0);
    check("stray_rready", {31'd0, s_rready}, 32'd0);
    check("stray_iret",   {31'd0, s_iret},   32'd0);
    beat(4'd2, 1'b1);
    check("bad_id_rready", {31'd0, s_rready}, 32'd0);

    // Reset in the middle of the dcache burst.
    beat(4'd1, 1'b0);
    check("burst_beat1", {31'd0, s_dret}, 32'd1);
    rvalid = 1; rid = 4'd1; rlast = 0;
    aresetn = 0;
    tick();
    check("midrst_rready",  {31'd0, rready},      32'd0);
    check("midrst_dret",    {31'd0, d_ret_valid}, 32'd0);
    check("midrst_arvalid", {31'd0, arvalid},     32'd0);
    check("midrst_araddr",  araddr,               32'd0);
    check("midrst_arlen",   {24'd0, arlen},       32'd0);
    rvalid = 0; aresetn = 1;
    d_rd_req = 1; d_rd_addr = 32'h4000; d_rd_burst = 0;
    wait_hs("d_after_rst", 4'd1, 32'h4000, 8'd0);
    repeat (2) tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
